// File: rtl/seq_pkg.sv
// Shared types for the datapath sequencer: opcode and FSM state encodings,
// plus the ALU select codes driven to the datapath.
package seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADD = 3'b101,
        OP_OUT = 3'b110,
        OP_ILL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_EMIT = 2'd2
    } seq_state_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

endpackage

// File: rtl/seq_decode.sv
// Purely combinational opcode decode for the sequencer.
module seq_decode
    import seq_pkg::*;
(
    input  logic [2:0] op,
    output logic       is_alu,
    output logic       is_ldi,
    output logic       is_out,
    output logic       is_illegal,
    output logic [1:0] alu_sel
);

    // Classify the opcode and pick the ALU operation for ALU-class opcodes.
    always_comb begin
        is_alu     = 1'b0;
        is_ldi     = 1'b0;
        is_out     = 1'b0;
        is_illegal = 1'b0;
        alu_sel    = ALU_AND;
        case (opcode_e'(op))
            OP_LDI: is_ldi = 1'b1;
            OP_AND: begin is_alu = 1'b1; alu_sel = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_sel = ALU_OR;  end
            OP_XOR: begin is_alu = 1'b1; alu_sel = ALU_XOR; end
            OP_ADD: begin is_alu = 1'b1; alu_sel = ALU_ADD; end
            OP_OUT: is_out = 1'b1;
            OP_ILL: is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Instruction sequencer driving a small 4-bit datapath (mux, ALU, register).
// IDLE accepts one instruction; EXEC pulses the register load for one cycle;
// EMIT presents the captured register value until the consumer takes it.
// Optional feature macro: SEQ_FLAGS_EN adds carry/zero flag snapshots.
module dp_sequencer
    import seq_pkg::*;
#(
    parameter int IMM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [IMM_W-1:0] instr_imm,
    output logic [IMM_W-1:0] mux_in_data,
    output logic             mux_sel_data,
    output logic             load,
    output logic [1:0]       alu_sel_data,
    output logic [IMM_W-1:0] alu_in_data,
    input  logic [IMM_W-1:0] reg_out,
    input  logic             carry_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IMM_W-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             illegal
);

    seq_state_e       state_reg, state_next;
    logic [2:0]       op_reg;
    logic [IMM_W-1:0] imm_reg;
    logic [IMM_W-1:0] res_data_reg;
    logic             illegal_reg;

    logic [2:0]       dec_op;
    logic             dec_is_alu, dec_is_ldi, dec_is_out, dec_is_illegal;
    logic [1:0]       dec_alu_sel;
    logic             accept;

    assign instr_ready = (state_reg == ST_IDLE);
    assign accept      = instr_valid && instr_ready;

    // One decoder serves both phases: the offered opcode while IDLE (for
    // the branch decision), the held opcode otherwise (so EXEC outputs
    // depend only on registered state).
    assign dec_op = (state_reg == ST_IDLE) ? instr_op : op_reg;

    seq_decode u_decode (
        .op         (dec_op),
        .is_alu     (dec_is_alu),
        .is_ldi     (dec_is_ldi),
        .is_out     (dec_is_out),
        .is_illegal (dec_is_illegal),
        .alu_sel    (dec_alu_sel)
    );

    // State, held instruction, result capture and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= 3'b000;
            imm_reg      <= '0;
            res_data_reg <= '0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= instr_op;
                imm_reg <= instr_imm;
            end
            if (accept && dec_is_out) begin
                res_data_reg <= reg_out;
            end
            if (accept && dec_is_illegal) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    // Next-state logic and datapath control; controls are idle outside EXEC.
    always_comb begin
        state_next   = state_reg;
        load         = 1'b0;
        mux_sel_data = 1'b0;
        mux_in_data  = '0;
        alu_in_data  = '0;
        alu_sel_data = ALU_AND;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_is_alu || dec_is_ldi) begin
                        state_next = ST_EXEC;
                    end else if (dec_is_out) begin
                        state_next = ST_EMIT;
                    end
                end
            end
            ST_EXEC: begin
                // Reset must suppress the load even mid-instruction.
                load         = !rst;
                mux_sel_data = dec_is_alu;
                mux_in_data  = dec_is_ldi ? imm_reg : '0;
                alu_in_data  = dec_is_alu ? imm_reg : '0;
                alu_sel_data = dec_is_alu ? dec_alu_sel : ALU_AND;
                state_next   = ST_IDLE;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign res_valid = (state_reg == ST_EMIT);
    assign res_data  = res_data_reg;
    assign illegal   = illegal_reg;

`ifdef SEQ_FLAGS_EN
    logic carry_reg;
    logic zero_reg;

    // Carry snapshots the adder carry at the end of ADD, clears for other
    // loading ops; zero is taken from the register as the result is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_EXEC) begin
                carry_reg <= dec_is_alu && (dec_alu_sel == ALU_ADD) && carry_out;
            end
            if (accept && dec_is_out) begin
                zero_reg <= (reg_out == '0);
            end
        end
    end

    assign res_carry = carry_reg;
    assign res_zero  = zero_reg;
`else
    logic unused_carry;
    assign unused_carry = carry_out;
    assign res_carry    = 1'b0;
    assign res_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer with a simple 4-bit datapath attached.
// The reference model tracks the accumulator, carry and illegal flag from the
// instruction semantics alone.
module tb_dp_sequencer;

`ifdef SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'b000, LDI = 3'b001, ANDI = 3'b010, ORI = 3'b011;
    localparam logic [2:0] XORI = 3'b100, ADDI = 3'b101, OUTI = 3'b110, ILLI = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'b000;
    logic [3:0] instr_imm = 4'h0;
    logic [3:0] mux_in_data;
    logic       mux_sel_data;
    logic       load;
    logic [1:0] alu_sel_data;
    logic [3:0] alu_in_data;
    logic [3:0] reg_out;
    logic       carry_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_acc   = 4'h0;
    logic       m_carry = 1'b0;
    logic       m_ill   = 1'b0;

    always #5 clk = ~clk;

    dp_sequencer #(.IMM_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_imm    (instr_imm),
        .mux_in_data  (mux_in_data),
        .mux_sel_data (mux_sel_data),
        .load         (load),
        .alu_sel_data (alu_sel_data),
        .alu_in_data  (alu_in_data),
        .reg_out      (reg_out),
        .carry_out    (carry_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .res_zero     (res_zero),
        .illegal      (illegal)
    );

    // Attached datapath: register fed by an immediate/ALU mux.
    logic [3:0] dp_reg = 4'h0;
    logic [4:0] dp_sum;
    assign dp_sum    = {1'b0, dp_reg} + {1'b0, alu_in_data};
    assign carry_out = dp_sum[4];
    assign reg_out   = dp_reg;

    always @(posedge clk) begin
        if (load) begin
            if (!mux_sel_data) dp_reg <= mux_in_data;
            else begin
                case (alu_sel_data)
                    2'b00: dp_reg <= dp_reg & alu_in_data;
                    2'b01: dp_reg <= dp_reg | alu_in_data;
                    2'b10: dp_reg <= dp_reg ^ alu_in_data;
                    default: dp_reg <= dp_sum[3:0];
                endcase
            end
        end
    end

    // Instruction semantics of the reference model.
    task automatic model_step(input logic [2:0] op, input logic [3:0] imm);
        logic [4:0] s;
        case (op)
            LDI:  begin m_acc = imm; m_carry = 1'b0; end
            ANDI: begin m_acc = m_acc & imm; m_carry = 1'b0; end
            ORI:  begin m_acc = m_acc | imm; m_carry = 1'b0; end
            XORI: begin m_acc = m_acc ^ imm; m_carry = 1'b0; end
            ADDI: begin s = {1'b0, m_acc} + {1'b0, imm}; m_acc = s[3:0]; m_carry = s[4]; end
            ILLI: m_ill = 1'b1;
            default: ;
        endcase
    endtask

    function automatic logic [1:0] exp_alu_sel(input logic [2:0] op);
        case (op)
            ANDI: return 2'b00;
            ORI:  return 2'b01;
            XORI: return 2'b10;
            ADDI: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Offer one instruction for exactly one clock edge; returns at edge+1.
    task automatic send(input logic [2:0] op, input logic [3:0] imm);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_imm = imm;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr_op = 3'b000; instr_imm = 4'h0;
        $display("txn op=%b imm=%h t=%0t", op, imm, $time);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        m_carry = 1'b0; m_ill = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", load); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        n_checks++; if (res_data !== 4'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        n_checks++; if ({res_carry, res_zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {res_carry, res_zero}); end
    endtask

    task automatic test_ldi_out();
        send(LDI, 4'b0101); model_step(LDI, 4'b0101);
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL ldi_load: got %b want 1", load); end
        n_checks++; if (mux_sel_data !== 1'b0) begin n_fail++; $display("FAIL ldi_mux_sel: got %b want 0", mux_sel_data); end
        n_checks++; if (mux_in_data !== 4'b0101) begin n_fail++; $display("FAIL ldi_mux_in: got %b want 0101", mux_in_data); end
        @(posedge clk); #1;
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL ldi_load_one_cycle: got %b want 0", load); end
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ldi_back_idle: got %b want 1", instr_ready); end
        res_ready = 1'b1;
        send(OUTI, 4'h0);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL ldi_out_valid: got %b want 1", res_valid); end
        n_checks++; if (res_data !== m_acc) begin n_fail++; $display("FAIL ldi_out_data: got %b want %b", res_data, m_acc); end
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ldi_out_done: got %b want 0", res_valid); end
    endtask

    task automatic test_add_carry();
        send(LDI, 4'b1100); model_step(LDI, 4'b1100);
        @(posedge clk); #1;
        send(ADDI, 4'b0110); model_step(ADDI, 4'b0110);
        n_checks++; if (alu_sel_data !== 2'b11) begin n_fail++; $display("FAIL add_alu_sel: got %b want 11", alu_sel_data); end
        n_checks++; if (mux_sel_data !== 1'b1) begin n_fail++; $display("FAIL add_mux_sel: got %b want 1", mux_sel_data); end
        n_checks++; if (alu_in_data !== 4'b0110) begin n_fail++; $display("FAIL add_alu_in: got %b want 0110", alu_in_data); end
        @(posedge clk); #1;
        send(OUTI, 4'h0);
        n_checks++; if (res_data !== 4'b0010) begin n_fail++; $display("FAIL add_res_data: got %b want 0010", res_data); end
        n_checks++; if (res_carry !== FLAGS) begin n_fail++; $display("FAIL add_res_carry: got %b want %b", res_carry, FLAGS); end
        n_checks++; if (res_zero !== 1'b0) begin n_fail++; $display("FAIL add_res_zero: got %b want 0", res_zero); end
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send(LDI, 4'b1001); model_step(LDI, 4'b1001);
        @(posedge clk); #1;
        send(OUTI, 4'h0);
        // Keep offering an instruction while the result is stalled.
        instr_valid = 1'b1; instr_op = LDI; instr_imm = 4'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (res_valid !== 1'b1 || res_data !== 4'b1001) begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%b want 1/1001", i, res_valid, res_data); end
            n_checks++; if (instr_ready !== 1'b0 || load !== 1'b0) begin n_fail++; $display("FAIL bp_blocked[%0d]: ready=%b load=%b want 0/0", i, instr_ready, load); end
            @(posedge clk); #1;
        end
        @(negedge clk); instr_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", res_valid, instr_ready); end
        n_checks++; if (reg_out !== 4'b1001) begin n_fail++; $display("FAIL bp_no_load: reg=%b want 1001", reg_out); end
    endtask

    task automatic test_illegal();
        send(ILLI, 4'hF); model_step(ILLI, 4'hF);
        n_checks++; if (load !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL ill_nop: load=%b ready=%b want 0/1", load, instr_ready); end
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_set: got %b want 1", illegal); end
        for (int i = 0; i < 3; i++) begin
            send(NOP, 4'(i));
            n_checks++; if (illegal !== 1'b1 || load !== 1'b0) begin n_fail++; $display("FAIL ill_sticky[%0d]: illegal=%b load=%b want 1/0", i, illegal, load); end
        end
        n_checks++; if (reg_out !== m_acc) begin n_fail++; $display("FAIL ill_reg: got %b want %b", reg_out, m_acc); end
        do_reset();
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_cleared: got %b want 0", illegal); end
    endtask

    task automatic test_reset_mid_exec();
        send(LDI, 4'b0011); model_step(LDI, 4'b0011);
        @(posedge clk); #1;
        send(ADDI, 4'b1110);
        rst = 1'b1; #1;
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL rst_exec_load: got %b want 0", load); end
        @(posedge clk); #1; rst = 1'b0;
        m_carry = 1'b0; m_ill = 1'b0;
        n_checks++; if (instr_ready !== 1'b1 || load !== 1'b0) begin n_fail++; $display("FAIL rst_exec_idle: ready=%b load=%b want 1/0", instr_ready, load); end
        n_checks++; if (reg_out !== m_acc) begin n_fail++; $display("FAIL rst_exec_reg: got %b want %b", reg_out, m_acc); end
        res_ready = 1'b1;
        send(OUTI, 4'h0);
        n_checks++; if (res_data !== m_acc || res_carry !== 1'b0) begin n_fail++; $display("FAIL rst_exec_out: data=%b carry=%b want %b/0", res_data, res_carry, m_acc); end
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = LDI; instr_imm = 4'b0011;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            if (load === 1'b1) loads++;
            if (i < 7) begin @(posedge clk); #1; end
        end
        instr_valid = 1'b0; instr_op = NOP; instr_imm = 4'h0;
        model_step(LDI, 4'b0011);
        n_checks++; if (loads != 4) begin n_fail++; $display("FAIL b2b_rate: loads=%0d want 4", loads); end
        @(posedge clk); #1;
        n_checks++; if (reg_out !== m_acc || instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_final: reg=%b ready=%b want %b/1", reg_out, instr_ready, m_acc); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] imm;
        int hold;
        for (int i = 0; i < 60; i++) begin
            op  = (i == 0) ? LDI : 3'($urandom_range(0, 7));
            imm = 4'($urandom_range(0, 15));
            n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", i, instr_ready); end
            send(op, imm);
            if (op >= LDI && op <= ADDI) begin
                n_checks++;
                if (load !== 1'b1 || mux_sel_data !== (op != LDI) || mux_in_data !== ((op == LDI) ? imm : 4'h0)
                    || alu_in_data !== ((op == LDI) ? 4'h0 : imm) || alu_sel_data !== exp_alu_sel(op)) begin
                    n_fail++;
                    $display("FAIL rnd_exec[%0d]: op=%b load=%b sel=%b in=%b alu=%b/%b want imm=%b alu_sel=%b",
                             i, op, load, mux_sel_data, mux_in_data, alu_sel_data, alu_in_data, imm, exp_alu_sel(op));
                end
                model_step(op, imm);
                @(posedge clk); #1;
                n_checks++; if (load !== 1'b0 || reg_out !== m_acc) begin n_fail++; $display("FAIL rnd_result[%0d]: load=%b reg=%b want 0/%b", i, load, reg_out, m_acc); end
            end else if (op == OUTI) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== m_acc || res_carry !== (FLAGS & m_carry) || res_zero !== (FLAGS & (m_acc == 4'h0))) begin
                    n_fail++;
                    $display("FAIL rnd_out[%0d]: valid=%b data=%b c=%b z=%b want 1/%b/%b/%b", i, res_valid, res_data, res_carry, res_zero,
                             m_acc, FLAGS & m_carry, FLAGS & (m_acc == 4'h0));
                end
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    n_checks++; if (res_valid !== 1'b1 || res_data !== m_acc || instr_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_hold[%0d]: valid=%b data=%b ready=%b", i, res_valid, res_data, instr_ready); end
                end
                @(negedge clk); res_ready = 1'b1;
                @(posedge clk); #1; res_ready = 1'b0;
                n_checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_release[%0d]: valid=%b ready=%b want 0/1", i, res_valid, instr_ready); end
            end else begin
                model_step(op, imm);
                n_checks++; if (load !== 1'b0 || illegal !== m_ill) begin n_fail++; $display("FAIL rnd_nop[%0d]: load=%b illegal=%b want 0/%b", i, load, illegal, m_ill); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi_out();
        test_add_carry();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
